// File: rtl/wb_stage_grf.sv
// Writeback select/extend plus 32x32 register file with two bypassed read ports and a retire counter.
// Write and count land one clock after the W bundle is presented; reads and bypass are zero-cycle; no backpressure.
module wb_stage_grf #(
    parameter int NREG = 32,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            movzW,
    input  logic [4:0]      WriteRegW,
    input  logic [31:0]     InstrutionW,
    input  logic [31:0]     PCouter8W,
    input  logic [31:0]     ReadDataW,
    input  logic [31:0]     ALUOutW,
    input  logic [4:0]      A1,
    input  logic [4:0]      A2,
    output logic [31:0]     RD1,
    output logic [31:0]     RD2,
    output logic [31:0]     WD,
    output logic            RegWriteEn,
    output logic [CNTW-1:0] RetireCnt
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic        is_movz;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] grf [NREG];

    assign op      = InstrutionW[31:26];
    assign fn      = InstrutionW[5:0];
    assign is_movz = (op == 6'b000000) && (fn == 6'b001010);

    always_comb begin
        byte_sel = ReadDataW[7:0];
        case (ALUOutW[1:0])
            2'd0: byte_sel = ReadDataW[7:0];
            2'd1: byte_sel = ReadDataW[15:8];
            2'd2: byte_sel = ReadDataW[23:16];
            2'd3: byte_sel = ReadDataW[31:24];
            default: byte_sel = ReadDataW[7:0];
        endcase
    end

    // Halfword offset comes from bit 1 only; misaligned bit 0 is ignored.
    assign half_sel = ALUOutW[1] ? ReadDataW[31:16] : ReadDataW[15:0];

    always_comb begin
        WD = ALUOutW;
        case (op)
            6'b100011: WD = ReadDataW;
            6'b100000: WD = {{24{byte_sel[7]}}, byte_sel};
            6'b100100: WD = {24'b0, byte_sel};
            6'b100001: WD = {{16{half_sel[15]}}, half_sel};
            6'b100101: WD = {16'b0, half_sel};
            6'b000011: WD = PCouter8W;
            6'b000000: WD = (fn == 6'b001001) ? PCouter8W : ALUOutW;
            default:   WD = ALUOutW;
        endcase
    end

    assign RegWriteEn = (WriteRegW != 5'd0) && !(is_movz && !movzW);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                grf[i] <= '0;
            end
        end else if (RegWriteEn) begin
            grf[WriteRegW] <= WD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RetireCnt <= '0;
        end else if (InstrutionW != 32'b0) begin
            RetireCnt <= RetireCnt + CNTW'(1);
        end
    end

    // Register 0 reads as zero regardless of array contents or bypass.
    always_comb begin
        RD1 = '0;
        if (A1 != 5'd0) begin
            RD1 = (RegWriteEn && (A1 == WriteRegW)) ? WD : grf[A1];
        end
    end

    always_comb begin
        RD2 = '0;
        if (A2 != 5'd0) begin
            RD2 = (RegWriteEn && (A2 == WriteRegW)) ? WD : grf[A2];
        end
    end

endmodule
